bound_flasher_gen: RTL and testbench
====================================

Name: bound_flasher_gen

Overview:
- Parametrised successor to the 16-lamp bound flasher.
- Drives a WIDTH-lamp thermometer bar through a fixed six-phase on/off sweep, started by `flick`.
- Supports configurable kick-back bounds, a step-rate prescaler, and status outputs (phase, busy, done) for a supervising controller.
- Sits directly between the user `flick` input and the lamp drivers.

Parameters:
- WIDTH, 16: number of lamps. Legal range 4..64.
- MID_LO, 5: lower kick-back lamp index. Requires 0 < MID_LO < MID_HI.
- MID_HI, 10: upper kick-back lamp index. Requires MID_HI < WIDTH-1.
- STEP_DIV, 1: clocks per lamp step. Must be >= 1.
- KICK_EN, 1: 1 enables kick-back; 0 makes `flick` start-only.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- flick, in, 1: start and kick-back request, level-sampled on step edges.
- led, out, WIDTH: lamp bar. led = (1<<lvl)-1.
- phase, out, 3: current phase code.
- busy, out, 1: 1 when phase != IDLE.
- done, out, 1: one-clock pulse on sweep completion.

Behaviour:
- Core state:
  - lvl: count of lit lamps, range 0..WIDTH, width clog2(WIDTH+1).
  - phase: 3-bit phase code.
  - prescaler counter: 0..STEP_DIV-1.
  - done register.
- Reset (reset=0, asynchronous): lvl=0, led=0, phase=IDLE, busy=0, done=0, prescaler=0. Takes effect immediately, including mid-sweep.
- Step tick:
  - Always 1 when STEP_DIV=1.
  - Otherwise 1 when the prescaler reaches STEP_DIV-1, then the prescaler wraps to 0.
  - Prescaler is held at 0 in IDLE.
- Sweep start:
  - IDLE with flick=1 at a clock edge: phase<=UP_FULL, lvl<=1, prescaler<=0.
  - Next step occurs STEP_DIV clocks later.
- Per-tick rules:
  - In UP phases lvl+=1; in DN phases lvl-=1.
  - Reaching a phase's target does not end the phase. The next tick both changes phase and applies the new direction, with no stall cycle.
- Phase sequence (target = lvl value at which the next tick turns around):
  - UP_FULL(1): target WIDTH, then DN_MID.
  - DN_MID(2): target MID_LO, then UP_MID.
  - UP_MID(3): target MID_HI+1, then DN_ZERO.
  - DN_ZERO(4): target 0, then UP_LO.
  - UP_LO(5): target MID_LO+1, then DN_END.
  - DN_END(6): the tick that makes lvl=0 also sets phase<=IDLE.
- done: registered; high for exactly the one clock after the edge that enters IDLE.
- Kick-back (KICK_EN=1; flick sampled only on tick edges):
  - UP_FULL, flick=1, lvl==MID_LO+1 or lvl==MID_HI+1: phase<=KICK_DN(7), lvl-=1. KICK_DN decrements to 0; the tick at lvl==0 sets phase<=UP_FULL, lvl<=1.
  - UP_MID, flick=1, lvl==MID_HI+1: phase<=DN_MID, lvl<=MID_HI. The sweep falls back to MID_LO and re-climbs.
  - Kick takes priority over the normal turnaround when both apply on the same tick.
- Held flick:
  - flick held high loops UP_FULL/KICK_DN indefinitely.
  - led never exceeds (1<<(MID_LO+1))-1 and done never pulses.
- flick is ignored outside IDLE and outside kick points.
- Default cycle length: 56 steps. With STEP_DIV=1 and the start edge as E0, lvl reaches 0 in DN_END at E55.
- Parameter violations are reported via an elaboration-time $error.

Decomposition:
- Package bound_flasher_pkg:
  - phase localparams IDLE=0, UP_FULL=1, DN_MID=2, UP_MID=3, DN_ZERO=4, UP_LO=5, DN_END=6, KICK_DN=7.
  - function therm(lvl) returning the thermometer code.
- Sub-module flash_step_timer (param STEP_DIV):
  - inputs clk, reset, run; output tick.
  - Holds the prescaler, cleared when run=0.
- Top level holds the phase FSM, the lvl counter and the done register.

Test Plan:
- Reset: pulse reset=0 while led=16'h0FFF mid-sweep -> led=0, phase=0, busy=0 asynchronously. After release, no change until flick.
- Straight cycle (defaults): flick=1 for 1 clock -> led 0x0001..0xFFFF, down to 0x001F, up to 0x07FF, down to 0, up to 0x003F, down to 0. done pulses 56 clocks after start, exactly once.
- Low kick-back: flick held 1 -> led cycles 0x0001..0x003F, 0x001F..0x0000, repeating. busy stays 1; done never asserts.
- Mid kick-back: flick pulsed; flick=1 again at UP_MID lvl=11 (led 0x07FF) -> led descends to 0x001F, re-climbs to 0x07FF, then proceeds to DN_ZERO once flick=0.
- KICK_EN=0: flick held 1 -> plain 56-step cycle, then an immediate restart from IDLE on the next edge.
- WIDTH=8, MID_LO=2, MID_HI=5, STEP_DIV=4: flick pulse -> 30 steps, one every 4 clocks, peak led=8'hFF. Final step 116 clocks after the start edge; done one clock later.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bound_flasher_pkg
//  Description : Shared phase codes and thermometer helper for bound_flasher_gen
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package bound_flasher_pkg;

   typedef logic [2:0] phase_t;

   localparam phase_t IDLE    = 3'd0;
   localparam phase_t UP_FULL = 3'd1;
   localparam phase_t DN_MID  = 3'd2;
   localparam phase_t UP_MID  = 3'd3;
   localparam phase_t DN_ZERO = 3'd4;
   localparam phase_t UP_LO   = 3'd5;
   localparam phase_t DN_END  = 3'd6;
   localparam phase_t KICK_DN = 3'd7;

   localparam int c_MAX_WIDTH = 64;

   // Lamp bar with the lowest lvl lamps lit; callers truncate to their width.
   function automatic logic [c_MAX_WIDTH-1:0] therm(input logic [6:0] lvl);
      logic [c_MAX_WIDTH-1:0] t;
      for (int i = 0; i < c_MAX_WIDTH; i++) begin
         t[i] = (i < int'(lvl));
      end
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bound_flasher_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : bound_flasher_gen_if
//  Description : flick request and lamp/status bundle of the bound flasher
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
interface bound_flasher_gen_if #(
   parameter int WIDTH = 16
);
   import bound_flasher_pkg::*;

   logic             flick;
   logic [WIDTH-1:0] led;
   phase_t           phase;
   logic             busy;
   logic             done;

   modport master (output flick, input led, phase, busy, done);
   modport slave  (input flick, output led, phase, busy, done);

endinterface
`default_nettype wire

// File: rtl/flash_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_step_timer
//  Description : Step-rate prescaler; tick fires every STEP_DIV clocks while run
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module flash_step_timer #(
   parameter int STEP_DIV = 1
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  run,
   output logic tick
);

   localparam int                c_CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(STEP_DIV - 1);

   logic [c_CW-1:0] r_cnt;

   // With STEP_DIV=1 the counter never leaves 0, so tick is permanently high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!run || (r_cnt == c_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

   assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/bound_flasher_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bound_flasher_gen
//  Description : WIDTH-lamp six-phase bound flasher with kick-back and status
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module bound_flasher_gen #(
   parameter int WIDTH    = 16,
   parameter int MID_LO   = 5,
   parameter int MID_HI   = 10,
   parameter int STEP_DIV = 1,
   parameter int KICK_EN  = 1
) (
   input  wire                clk,
   input  wire                reset,
   bound_flasher_gen_if.slave bus
);
   import bound_flasher_pkg::*;

   localparam int              c_LW   = $clog2(WIDTH + 1);
   localparam logic [c_LW-1:0] c_ZERO = '0;
   localparam logic [c_LW-1:0] c_ONE  = c_LW'(1);
   localparam logic [c_LW-1:0] c_FULL = c_LW'(WIDTH);
   localparam logic [c_LW-1:0] c_LO   = c_LW'(MID_LO);
   localparam logic [c_LW-1:0] c_LO1  = c_LW'(MID_LO + 1);
   localparam logic [c_LW-1:0] c_HI   = c_LW'(MID_HI);
   localparam logic [c_LW-1:0] c_HI1  = c_LW'(MID_HI + 1);

   if ((WIDTH < 4) || (WIDTH > 64) || (MID_LO < 1) || (MID_LO >= MID_HI) ||
       (MID_HI >= WIDTH - 1) || (STEP_DIV < 1) || (KICK_EN < 0) || (KICK_EN > 1))
   begin : g_param_check
      $error("bound_flasher_gen: illegal parameter combination");
   end

   phase_t          r_phase, w_phase_nxt;
   logic [c_LW-1:0] r_lvl,   w_lvl_nxt;
   logic            r_done,  w_done_nxt;
   logic [c_LW-1:0] w_inc,   w_dec;
   logic            w_run,   w_tick,  w_kick;

   assign w_run  = (r_phase != IDLE);
   assign w_kick = (KICK_EN != 0) && bus.flick;
   assign w_inc  = r_lvl + c_ONE;
   assign w_dec  = r_lvl - c_ONE;

   flash_step_timer #(
      .STEP_DIV (STEP_DIV)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .run   (w_run),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase <= IDLE;
         r_lvl   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_lvl   <= w_lvl_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // A target is only acted on by the following tick, which turns and moves at once.
   always_comb begin
      w_phase_nxt = r_phase;
      w_lvl_nxt   = r_lvl;
      w_done_nxt  = 1'b0;
      if (r_phase == IDLE) begin
         if (bus.flick) begin
            w_phase_nxt = UP_FULL;
            w_lvl_nxt   = c_ONE;
         end
      end else if (w_tick) begin
         case (r_phase)
            UP_FULL: begin
               if (w_kick && ((r_lvl == c_LO1) || (r_lvl == c_HI1))) begin
                  w_phase_nxt = KICK_DN;
                  w_lvl_nxt   = w_dec;
               end else if (r_lvl == c_FULL) begin
                  w_phase_nxt = DN_MID;
                  w_lvl_nxt   = w_dec;
               end else begin
                  w_lvl_nxt   = w_inc;
               end
            end
            DN_MID: begin
               if (r_lvl == c_LO) begin
                  w_phase_nxt = UP_MID;
                  w_lvl_nxt   = w_inc;
               end else begin
                  w_lvl_nxt   = w_dec;
               end
            end
            UP_MID: begin
               if (w_kick && (r_lvl == c_HI1)) begin
                  w_phase_nxt = DN_MID;
                  w_lvl_nxt   = c_HI;
               end else if (r_lvl == c_HI1) begin
                  w_phase_nxt = DN_ZERO;
                  w_lvl_nxt   = w_dec;
               end else begin
                  w_lvl_nxt   = w_inc;
               end
            end
            DN_ZERO: begin
               if (r_lvl == c_ZERO) begin
                  w_phase_nxt = UP_LO;
                  w_lvl_nxt   = w_inc;
               end else begin
                  w_lvl_nxt   = w_dec;
               end
            end
            UP_LO: begin
               if (r_lvl == c_LO1) begin
                  w_phase_nxt = DN_END;
                  w_lvl_nxt   = w_dec;
               end else begin
                  w_lvl_nxt   = w_inc;
               end
            end
            DN_END: begin
               w_lvl_nxt = w_dec;
               if (r_lvl == c_ONE) begin
                  w_phase_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            KICK_DN: begin
               if (r_lvl == c_ZERO) begin
                  w_phase_nxt = UP_FULL;
                  w_lvl_nxt   = c_ONE;
               end else begin
                  w_lvl_nxt   = w_dec;
               end
            end
            default: begin
               w_phase_nxt = IDLE;
               w_lvl_nxt   = c_ZERO;
            end
         endcase
      end
   end

   always_comb begin
      bus.led   = WIDTH'(therm(7'(r_lvl)));
      bus.phase = r_phase;
      bus.busy  = (r_phase != IDLE);
      bus.done  = r_done;
   end

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bound_flasher_gen
//  Description : Directed self-checking bench for bound_flasher_gen variants
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module tb_bound_flasher_gen;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_done0  = 0;
   int   n_done2  = 0;

   always #5 clk = ~clk;

   bound_flasher_gen_if #(.WIDTH(16)) if0 ();
   bound_flasher_gen_if #(.WIDTH(16)) if1 ();
   bound_flasher_gen_if #(.WIDTH(8))  if2 ();

   bound_flasher_gen #(
      .WIDTH(16), .MID_LO(5), .MID_HI(10), .STEP_DIV(1), .KICK_EN(1)
   ) u_dut0 (.clk(clk), .reset(reset_n), .bus(if0.slave));

   bound_flasher_gen #(
      .WIDTH(16), .MID_LO(5), .MID_HI(10), .STEP_DIV(1), .KICK_EN(0)
   ) u_dut1 (.clk(clk), .reset(reset_n), .bus(if1.slave));

   bound_flasher_gen #(
      .WIDTH(8), .MID_LO(2), .MID_HI(5), .STEP_DIV(4), .KICK_EN(1)
   ) u_dut2 (.clk(clk), .reset(reset_n), .bus(if2.slave));

   always @(negedge clk) begin
      if (if0.done === 1'b1) n_done0++;
      if (if2.done === 1'b1) n_done2++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : main
      int         d0;
      logic [15:0] max_led;
      logic        all_busy;
      int          waited;

      if0.flick = 1'b0;
      if1.flick = 1'b0;
      if2.flick = 1'b0;

      // power-on reset
      clocks(3);
      check("rst_led",   64'(if0.led),   64'h0);
      check("rst_phase", 64'(if0.phase), 64'd0);
      check("rst_busy",  64'(if0.busy),  64'd0);
      check("rst_done",  64'(if0.done),  64'd0);
      reset_n = 1'b1;
      clocks(3);
      check("idle_led",   64'(if0.led),   64'h0);
      check("idle_phase", 64'(if0.phase), 64'd0);

      // straight cycle, start edge = E0
      d0 = n_done0;
      if0.flick = 1'b1;
      clocks(1);
      if0.flick = 1'b0;
      check("s_e0_led",   64'(if0.led),   64'h0001);
      check("s_e0_phase", 64'(if0.phase), 64'd1);
      check("s_e0_busy",  64'(if0.busy),  64'd1);
      clocks(15);
      check("s_e15_led",  64'(if0.led),   64'hFFFF);
      clocks(1);
      check("s_e16_led",  64'(if0.led),   64'h7FFF);
      check("s_e16_ph",   64'(if0.phase), 64'd2);
      clocks(10);
      check("s_e26_led",  64'(if0.led),   64'h001F);
      clocks(1);
      check("s_e27_led",  64'(if0.led),   64'h003F);
      check("s_e27_ph",   64'(if0.phase), 64'd3);
      clocks(5);
      check("s_e32_led",  64'(if0.led),   64'h07FF);
      clocks(1);
      check("s_e33_led",  64'(if0.led),   64'h03FF);
      check("s_e33_ph",   64'(if0.phase), 64'd4);
      clocks(10);
      check("s_e43_led",  64'(if0.led),   64'h0000);
      clocks(1);
      check("s_e44_ph",   64'(if0.phase), 64'd5);
      clocks(5);
      check("s_e49_led",  64'(if0.led),   64'h003F);
      clocks(1);
      check("s_e50_led",  64'(if0.led),   64'h001F);
      check("s_e50_ph",   64'(if0.phase), 64'd6);
      clocks(4);
      check("s_e54_led",  64'(if0.led),   64'h0001);
      check("s_e54_done", 64'(if0.done),  64'd0);
      clocks(1);
      check("s_e55_led",  64'(if0.led),   64'h0000);
      check("s_e55_ph",   64'(if0.phase), 64'd0);
      check("s_e55_busy", 64'(if0.busy),  64'd0);
      check("s_e55_done", 64'(if0.done),  64'd1);
      clocks(1);
      check("s_e56_done", 64'(if0.done),  64'd0);
      clocks(4);
      check("s_done_cnt", 64'(n_done0 - d0), 64'd1);

      // asynchronous reset mid-sweep
      if0.flick = 1'b1;
      clocks(1);
      if0.flick = 1'b0;
      clocks(11);
      check("r_pre_led", 64'(if0.led), 64'h0FFF);
      #3 reset_n = 1'b0;
      #1;
      check("r_async_led",   64'(if0.led),   64'h0);
      check("r_async_phase", 64'(if0.phase), 64'd0);
      check("r_async_busy",  64'(if0.busy),  64'd0);
      #2 reset_n = 1'b1;
      clocks(3);
      check("r_post_led",   64'(if0.led),   64'h0);
      check("r_post_phase", 64'(if0.phase), 64'd0);

      // low kick-back with flick held
      d0 = n_done0;
      if0.flick = 1'b1;
      clocks(1);
      check("k_e0_led",  64'(if0.led),   64'h0001);
      clocks(5);
      check("k_e5_led",  64'(if0.led),   64'h003F);
      clocks(1);
      check("k_e6_led",  64'(if0.led),   64'h001F);
      check("k_e6_ph",   64'(if0.phase), 64'd7);
      clocks(5);
      check("k_e11_led", 64'(if0.led),   64'h0000);
      clocks(1);
      check("k_e12_led", 64'(if0.led),   64'h0001);
      check("k_e12_ph",  64'(if0.phase), 64'd1);
      max_led  = 16'h0;
      all_busy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         clocks(1);
         if (if0.led > max_led) max_led = if0.led;
         if (if0.busy !== 1'b1) all_busy = 1'b0;
      end
      check("k_max_led",  64'(max_led),  64'h003F);
      check("k_all_busy", 64'(all_busy), 64'd1);
      check("k_no_done",  64'(n_done0 - d0), 64'd0);
      if0.flick = 1'b0;
      waited = 0;
      while ((if0.busy === 1'b1) && (waited < 200)) begin
         clocks(1);
         waited++;
      end
      check("k_release_idle", 64'(if0.busy), 64'd0);

      // mid kick-back from UP_MID
      clocks(2);
      if0.flick = 1'b1;
      clocks(1);
      if0.flick = 1'b0;
      clocks(32);
      check("m_e32_led", 64'(if0.led),   64'h07FF);
      check("m_e32_ph",  64'(if0.phase), 64'd3);
      if0.flick = 1'b1;
      clocks(1);
      if0.flick = 1'b0;
      check("m_e33_led", 64'(if0.led),   64'h03FF);
      check("m_e33_ph",  64'(if0.phase), 64'd2);
      clocks(5);
      check("m_e38_led", 64'(if0.led),   64'h001F);
      clocks(6);
      check("m_e44_led", 64'(if0.led),   64'h07FF);
      check("m_e44_ph",  64'(if0.phase), 64'd3);
      clocks(1);
      check("m_e45_led", 64'(if0.led),   64'h03FF);
      check("m_e45_ph",  64'(if0.phase), 64'd4);
      clocks(22);
      check("m_e67_ph",   64'(if0.phase), 64'd0);
      check("m_e67_done", 64'(if0.done),  64'd1);

      // KICK_EN=0, flick held
      if1.flick = 1'b1;
      clocks(1);
      check("n_e0_led",   64'(if1.led),   64'h0001);
      clocks(6);
      check("n_e6_led",   64'(if1.led),   64'h007F);
      check("n_e6_ph",    64'(if1.phase), 64'd1);
      clocks(49);
      check("n_e55_ph",   64'(if1.phase), 64'd0);
      check("n_e55_done", 64'(if1.done),  64'd1);
      clocks(1);
      check("n_e56_led",  64'(if1.led),   64'h0001);
      check("n_e56_ph",   64'(if1.phase), 64'd1);
      if1.flick = 1'b0;
      clocks(55);
      check("n_e111_ph",  64'(if1.phase), 64'd0);

      // WIDTH=8, MID_LO=2, MID_HI=5, STEP_DIV=4
      d0 = n_done2;
      if2.flick = 1'b1;
      clocks(1);
      if2.flick = 1'b0;
      check("w_e0_led",    64'(if2.led),   64'h01);
      clocks(3);
      check("w_e3_led",    64'(if2.led),   64'h01);
      clocks(1);
      check("w_e4_led",    64'(if2.led),   64'h03);
      clocks(24);
      check("w_e28_led",   64'(if2.led),   64'hFF);
      clocks(4);
      check("w_e32_led",   64'(if2.led),   64'h7F);
      check("w_e32_ph",    64'(if2.phase), 64'd2);
      clocks(40);
      check("w_e72_led",   64'(if2.led),   64'h1F);
      check("w_e72_ph",    64'(if2.phase), 64'd4);
      clocks(43);
      check("w_e115_led",  64'(if2.led),   64'h01);
      check("w_e115_ph",   64'(if2.phase), 64'd6);
      check("w_e115_done", 64'(if2.done),  64'd0);
      clocks(1);
      check("w_e116_led",  64'(if2.led),   64'h00);
      check("w_e116_ph",   64'(if2.phase), 64'd0);
      check("w_e116_done", 64'(if2.done),  64'd1);
      clocks(1);
      check("w_e117_done", 64'(if2.done),  64'd0);
      check("w_done_cnt",  64'(n_done2 - d0), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
